// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the int_ctrl interrupt controller:
// register offsets, VECTOR layout and FSM state encoding.
package int_ctrl_pkg;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_MODE    = 2'd3;

    localparam int VECTOR_VALID_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module int_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         found_o,
    output logic [3:0]   id_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        found_o = 1'b0;
        id_o    = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                id_o    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller in front of the RISC5 CPU.
// Synchronizes NUM_IRQ sources, masks and prioritizes them, drives the CPU
// irq line and tracks the in-service source for handler dispatch.
// Optional level-triggered sources are enabled by defining INT_CTRL_LEVEL_EN.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               intack,
    input  logic               rti,
    input  logic               intabort,
    input  logic               io_en,
    input  logic               rd,
    input  logic               wr,
    input  logic [1:0]         adr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               irq
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_prev_q;
    logic [NUM_IRQ-1:0] sync_out;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] isr_clr_mask;
    logic [NUM_IRQ-1:0] wdata;
    logic               wr_en;
    logic               found;
    logic [3:0]         sel_id;
    logic               take;
    state_e             state_q, state_d;
    logic [3:0]         isr_id_q, isr_id_d;
    logic               isr_valid_q, isr_valid_d;
    logic               irq_q;

    // Read strobe is not needed (reads are side-effect free); upper write bits ignored
    logic unused_ok;
    assign unused_ok = ^{rd, data_in};

    assign wr_en = io_en & wr;
    assign wdata = data_in[NUM_IRQ-1:0];

    // Multi-flop synchronizer per source plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_prev_q;

`ifdef INT_CTRL_LEVEL_EN
    logic [NUM_IRQ-1:0] mode_q;

    // MODE register: a set bit makes that source level-triggered
    always_ff @(posedge clk) begin
        if (!rst)                            mode_q <= '0;
        else if (wr_en && adr == REG_MODE)   mode_q <= wdata;
    end

    assign mode = mode_q;
`else
    assign mode = '0;
`endif

    // Level sources follow the synchronized input; edge sources use the latch
    assign pending = (pend_q & ~mode) | (sync_out & mode);
    assign req     = pending & enable_q;

    int_prio_enc #(.N(NUM_IRQ)) u_prio (
        .req_i   (req),
        .found_o (found),
        .id_o    (sel_id)
    );

    // intack only clears the pending bit when the acknowledge is actually taken
    assign take = (state_q == ST_REQ) && intack && !intabort && found;

    // Next-state for ENABLE and PENDING; a fresh edge overrides any clear
    always_comb begin
        enable_d = enable_q;
        if (wr_en && adr == REG_ENABLE) enable_d = wdata;

        for (int i = 0; i < NUM_IRQ; i++) isr_clr_mask[i] = take && (sel_id == 4'(i));

        pend_d = pend_q;
        if (wr_en && adr == REG_PENDING) pend_d = pend_d & ~wdata;
        pend_d = pend_d & ~isr_clr_mask;
        pend_d = (pend_d | rise) & ~mode;
    end

    // Request/service FSM; abort overrides everything and always passes through GAP
    always_comb begin
        state_d     = state_q;
        isr_id_d    = isr_id_q;
        isr_valid_d = isr_valid_q;
        if (intabort) begin
            isr_valid_d = 1'b0;
            isr_id_d    = 4'd0;
            state_d     = ST_GAP;
        end else begin
            case (state_q)
                ST_IDLE: if (found) state_d = ST_REQ;
                ST_REQ: begin
                    if (!found) begin
                        state_d = ST_IDLE;
                    end else if (intack) begin
                        isr_id_d    = sel_id;
                        isr_valid_d = 1'b1;
                        state_d     = ST_SERV;
                    end
                end
                ST_SERV: begin
                    if (rti) begin
                        isr_valid_d = 1'b0;
                        isr_id_d    = 4'd0;
                        state_d     = ST_GAP;
                    end
                end
                ST_GAP:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, register file and registered irq output
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            enable_q    <= '0;
            pend_q      <= '0;
            isr_id_q    <= 4'd0;
            isr_valid_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            pend_q      <= pend_d;
            isr_id_q    <= isr_id_d;
            isr_valid_q <= isr_valid_d;
            irq_q       <= (state_d == ST_REQ);
        end
    end

    assign irq = irq_q;

    // Combinational read mux, silent when this block is not selected
    always_comb begin
        data_out = 32'd0;
        if (io_en) begin
            case (adr)
                REG_ENABLE:  data_out = 32'(enable_q);
                REG_PENDING: data_out = 32'(pending);
                REG_VECTOR: begin
                    data_out[VECTOR_VALID_BIT] = isr_valid_q;
                    data_out[3:0]              = isr_id_q;
                end
                REG_MODE:    data_out = 32'(mode);
                default:     data_out = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: the driver pushes expected values, a monitor
// pops and compares them whenever the DUT is read or irq is sampled.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic               intack = 1'b0;
    logic               rti = 1'b0;
    logic               intabort = 1'b0;
    logic               io_en = 1'b0;
    logic               rd = 1'b0;
    logic               wr = 1'b0;
    logic [1:0]         adr = 2'd0;
    logic [31:0]        data_in = 32'd0;
    logic [31:0]        data_out;
    logic               irq;

    logic               chk_irq = 1'b0;
    bit                 kind_q [$];
    logic [31:0]        exp_q  [$];
    string              name_q [$];
    int                 checks = 0;
    int                 errors = 0;

    int_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .intack   (intack),
        .rti      (rti),
        .intabort (intabort),
        .io_en    (io_en),
        .rd       (rd),
        .wr       (wr),
        .adr      (adr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Monitor: compare DUT output against the oldest expectation
    always @(negedge clk) begin
        bit          k;
        logic [31:0] e;
        logic [31:0] act;
        string       n;
        if (chk_irq || (io_en && rd)) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: DUT output seen with no expected entry");
            end else begin
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act = k ? {31'd0, irq} : data_out;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit k, input logic [31:0] e, input string n);
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string n);
        push(1'b0, e, n);
        io_en = 1'b1; rd = 1'b1; adr = a;
        tick();
        io_en = 1'b0; rd = 1'b0;
    endtask

    task automatic irq_chk(input logic e, input string n);
        push(1'b1, {31'd0, e}, n);
        chk_irq = 1'b1;
        tick();
        chk_irq = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        io_en = 1'b1; wr = 1'b1; adr = a; data_in = d;
        tick();
        io_en = 1'b0; wr = 1'b0; data_in = 32'd0;
    endtask

    task automatic pulse_ack();
        intack = 1'b1; tick(); intack = 1'b0;
    endtask

    task automatic pulse_rti();
        rti = 1'b1; tick(); rti = 1'b0;
    endtask

    task automatic wait_irq(input logic e, input int max, input string n);
        int i;
        for (i = 0; i < max; i++) begin
            if (irq === e) break;
            tick();
        end
        if (i == max) begin
            checks++;
            errors++;
            $display("FAIL %s: irq=%0b after %0d cycles, required %0b", n, irq, max, e);
        end
    endtask

    initial begin
        // Reset
        tick(); tick();
        irq_chk(1'b0, "reset_irq");
        rst = 1'b1;
        rd_chk(REG_ENABLE,  32'h0, "reset_enable");
        rd_chk(REG_PENDING, 32'h0, "reset_pending");
        rd_chk(REG_VECTOR,  32'h0, "reset_vector");
        rd_chk(REG_MODE,    32'h0, "reset_mode");

        // Single source 3
        wr_reg(REG_ENABLE, 32'h08);
        irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
        tick(); tick();
        rd_chk(REG_PENDING, 32'h08, "single_pending");
        irq_chk(1'b1, "single_irq_rise");
        pulse_ack();
        irq_chk(1'b0, "single_irq_after_ack");
        rd_chk(REG_VECTOR,  32'h80000003, "single_vector");
        rd_chk(REG_PENDING, 32'h00, "single_pending_cleared");
        pulse_rti();
        irq_chk(1'b0, "single_gap_irq");
        rd_chk(REG_VECTOR, 32'h0, "single_vector_after_rti");

        // Priority and queuing: sources 5 and 2 together
        wr_reg(REG_ENABLE, 32'hFF);
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        wait_irq(1'b1, 10, "prio_wait_irq");
        irq_in = '0;
        rd_chk(REG_PENDING, 32'h24, "prio_pending");
        pulse_ack();
        rd_chk(REG_VECTOR,  32'h80000002, "prio_vector_2");
        rd_chk(REG_PENDING, 32'h20, "prio_pending_left");
        pulse_rti();
        irq_chk(1'b0, "prio_gap_irq");
        irq_chk(1'b0, "prio_idle_irq");
        irq_chk(1'b1, "prio_rerequest");
        pulse_ack();
        rd_chk(REG_VECTOR, 32'h80000005, "prio_vector_5");
        pulse_rti();
        tick(); tick();

        // Masking and W1C
        wr_reg(REG_ENABLE, 32'h00);
        irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
        tick(); tick(); tick();
        rd_chk(REG_PENDING, 32'h02, "mask_pending");
        irq_chk(1'b0, "mask_irq_low");
        wr_reg(REG_PENDING, 32'h02);
        rd_chk(REG_PENDING, 32'h00, "w1c_cleared");
        wr_reg(REG_ENABLE, 32'h02);
        irq_chk(1'b0, "w1c_irq_low_a");
        irq_chk(1'b0, "w1c_irq_low_b");

        // Abort while serving source 4 with source 6 pending
        wr_reg(REG_ENABLE, 32'h50);
        irq_in[4] = 1'b1; tick(); irq_in[4] = 1'b0;
        wait_irq(1'b1, 10, "abort_wait_irq");
        pulse_ack();
        rd_chk(REG_VECTOR, 32'h80000004, "abort_vector_4");
        irq_in[6] = 1'b1; tick(); irq_in[6] = 1'b0;
        tick(); tick();
        rd_chk(REG_PENDING, 32'h40, "abort_pending_6");
        intabort = 1'b1; tick(); intabort = 1'b0;
        rd_chk(REG_VECTOR,  32'h0, "abort_vector_clear");
        rd_chk(REG_PENDING, 32'h40, "abort_pending_kept");
        irq_chk(1'b1, "abort_rerequest");

        // intack together with intabort: abort wins, nothing is taken
        intack = 1'b1; intabort = 1'b1; tick(); intack = 1'b0; intabort = 1'b0;
        rd_chk(REG_VECTOR,  32'h0, "ackabort_vector");
        rd_chk(REG_PENDING, 32'h40, "ackabort_pending");
        irq_chk(1'b1, "ackabort_rerequest");
        pulse_ack();
        rd_chk(REG_VECTOR, 32'h80000006, "abort_vector_6");
        pulse_rti();
        tick(); tick();

        // Edge arriving in the same cycle as W1C of the same bit
        wr_reg(REG_ENABLE, 32'h00);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        tick(); tick();
        rd_chk(REG_PENDING, 32'h01, "coll_pending_first");
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        tick();
        wr_reg(REG_PENDING, 32'h01);
        rd_chk(REG_PENDING, 32'h01, "coll_edge_wins");
        wr_reg(REG_PENDING, 32'h01);
        rd_chk(REG_PENDING, 32'h00, "coll_plain_w1c");

`ifdef INT_CTRL_LEVEL_EN
        // Level source held high through rti is requested again
        wr_reg(REG_MODE, 32'h01);
        rd_chk(REG_MODE, 32'h01, "level_mode_rd");
        wr_reg(REG_ENABLE, 32'h01);
        irq_in[0] = 1'b1;
        wait_irq(1'b1, 10, "level_wait_irq");
        pulse_ack();
        rd_chk(REG_VECTOR,  32'h80000000, "level_vector");
        rd_chk(REG_PENDING, 32'h01, "level_pending_held");
        pulse_rti();
        irq_chk(1'b0, "level_gap_irq");
        irq_chk(1'b0, "level_idle_irq");
        irq_chk(1'b1, "level_rerequest");
        irq_in[0] = 1'b0;
        pulse_ack();
        pulse_rti();
        tick(); tick();
        rd_chk(REG_PENDING, 32'h00, "level_pending_drop");
`else
        wr_reg(REG_MODE, 32'h01);
        rd_chk(REG_MODE, 32'h00, "mode_ignored");
`endif

        tick();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
